// File: rtl/count_wrap_monitor.sv
// Wrap/period monitor for a free-running up-counter.
// Optional per-edge sequence check: COUNT_WRAP_MONITOR_STEP_CHECK_EN.
module count_wrap_monitor (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] cnt_in,
  input  logic [3:0] exp_mod,
  input  logic       clr,
  output logic       wrap_pulse,
  output logic [4:0] period_len,
  output logic       period_valid,
  output logic [7:0] wrap_count,
  output logic       locked,
  output logic       err_flag
);

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    LOCK,
    FAULT
  } state_t;

  state_t     state_q;
  logic [3:0] prev_q;
  logic [3:0] exp_q;
  logic [4:0] cyc_q;
  logic [4:0] cyc_d;
  logic [4:0] plen_q;
  logic [7:0] wcnt_q;
  logic       wp_q;
  logic       pv_q;

  logic       wrap;
  logic [4:0] exp_p1;
  logic       per_bad;
  logic       stall;
  logic       step_bad;
  logic       lock_fault;

  // A wrap needs a prior sample, which exists in every state but IDLE.
  assign wrap = (state_q != IDLE) && (cnt_in < prev_q);

  assign exp_p1  = {1'b0, exp_q} + 5'd1;
  assign per_bad = (cyc_q != exp_p1);
  assign stall   = (cyc_d == 5'd31);

`ifdef COUNT_WRAP_MONITOR_STEP_CHECK_EN
  logic [3:0] step_exp;

  // Next legal counter value given the captured terminal value.
  always_comb begin
    step_exp = prev_q + 4'd1;
    if (prev_q == exp_q) step_exp = 4'd0;
  end

  assign step_bad = (cnt_in != step_exp);
`else
  assign step_bad = 1'b0;
`endif

  // Period mismatch on a wrap, stall otherwise, plus optional step check.
  assign lock_fault = (wrap ? per_bad : stall) | step_bad;

  // Cycles-since-wrap counter, restarting at 1 and saturating at 31.
  always_comb begin
    cyc_d = cyc_q;
    if (wrap) begin
      cyc_d = 5'd1;
    end else if (cyc_q != 5'd31) begin
      cyc_d = cyc_q + 5'd1;
    end
  end

  // Monitor FSM with all measurement state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      prev_q  <= 4'd0;
      exp_q   <= 4'd0;
      cyc_q   <= 5'd0;
      plen_q  <= 5'd0;
      wcnt_q  <= 8'd0;
      wp_q    <= 1'b0;
      pv_q    <= 1'b0;
    end else begin
      prev_q <= cnt_in;
      wp_q   <= 1'b0;
      pv_q   <= 1'b0;
      if (clr) begin
        state_q <= SYNC;
        wcnt_q  <= 8'd0;
        plen_q  <= 5'd0;
        cyc_q   <= 5'd0;
      end else begin
        cyc_q <= cyc_d;
        unique case (state_q)
          IDLE: begin
            state_q <= SYNC;
          end
          SYNC: begin
            if (wrap) begin
              state_q <= LOCK;
              exp_q   <= exp_mod;
              wp_q    <= 1'b1;
            end
          end
          LOCK: begin
            if (wrap) begin
              wp_q   <= 1'b1;
              pv_q   <= 1'b1;
              plen_q <= cyc_q;
              wcnt_q <= wcnt_q + 8'd1;
            end
            if (lock_fault) state_q <= FAULT;
          end
          FAULT: begin
            if (wrap) wp_q <= 1'b1;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign wrap_pulse   = wp_q;
  assign period_valid = pv_q;
  assign period_len   = plen_q;
  assign wrap_count   = wcnt_q;
  assign locked       = (state_q == LOCK);
  assign err_flag     = (state_q == FAULT);

endmodule

// File: tb/tb_count_wrap_monitor.sv
// Directed bench for count_wrap_monitor.
// Honours COUNT_WRAP_MONITOR_STEP_CHECK_EN where behaviour differs.
module tb_count_wrap_monitor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] cnt_in;
  logic [3:0] exp_mod;
  logic       clr;
  logic       wrap_pulse;
  logic [4:0] period_len;
  logic       period_valid;
  logic [7:0] wrap_count;
  logic       locked;
  logic       err_flag;

  int checks   = 0;
  int failures = 0;
  int pv_cnt   = 0;
  int wp_cnt   = 0;

  always #5 clk = ~clk;

  count_wrap_monitor dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cnt_in      (cnt_in),
    .exp_mod     (exp_mod),
    .clr         (clr),
    .wrap_pulse  (wrap_pulse),
    .period_len  (period_len),
    .period_valid(period_valid),
    .wrap_count  (wrap_count),
    .locked      (locked),
    .err_flag    (err_flag)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Drive one sample, let the edge take it, observe 1ns later.
  task automatic tick(input int v);
    cnt_in = 4'(v);
    @(posedge clk);
    #1;
    pv_cnt += int'(period_valid);
    wp_cnt += int'(wrap_pulse);
  endtask

  // One counter period 0..last, with pulse counters restarted.
  task automatic feed(input int last);
    pv_cnt = 0;
    wp_cnt = 0;
    for (int i = 0; i <= last; i++) tick(i);
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    clr    = 1'b0;
    cnt_in = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic int outs_or();
    return int'(wrap_pulse) + int'(period_valid) + int'(locked)
         + int'(err_flag) + int'(period_len) + int'(wrap_count);
  endfunction

  int bad;
  int pvs;

  initial begin
    exp_mod = 4'd11;
    rst_n   = 1'b0;
    clr     = 1'b0;
    cnt_in  = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outs", outs_or(), 0);
    rst_n = 1'b1;

    // Clean 0..11 stream: lock, then 12-cycle periods.
    feed(11);
    chk("sync_nolock", int'(locked), 0);
    feed(11);
    chk("lock", int'(locked), 1);
    chk("lock_wp", wp_cnt, 1);
    chk("lock_wc", int'(wrap_count), 0);
    chk("lock_pv", pv_cnt, 0);
    feed(11);
    chk("p1_len", int'(period_len), 12);
    chk("p1_pv", pv_cnt, 1);
    chk("p1_wc", int'(wrap_count), 1);
    chk("p1_err", int'(err_flag), 0);
    feed(11);
    feed(11);
    chk("p3_pv", pv_cnt, 1);
    chk("p3_wc", int'(wrap_count), 3);
    chk("p3_len", int'(period_len), 12);

    // Short period (wraps at 9): fault on that wrap.
    feed(9);
    chk("p4_wc", int'(wrap_count), 4);
    feed(11);
    chk("short_len", int'(period_len), 10);
    chk("short_pv", pv_cnt, 1);
    chk("short_err", int'(err_flag), 1);
    chk("short_lock", int'(locked), 0);
    chk("short_wc", int'(wrap_count), 5);
    feed(11);
    chk("flt_wp", wp_cnt, 1);
    chk("flt_pv", pv_cnt, 0);
    chk("flt_wc", int'(wrap_count), 5);

    // Clear coinciding with a wrap edge.
    clr = 1'b1;
    tick(0);
    clr = 1'b0;
    chk("clr_wp", int'(wrap_pulse), 0);
    chk("clr_outs", outs_or(), 0);
    for (int i = 1; i <= 11; i++) tick(i);
    feed(11);
    chk("relock", int'(locked), 1);
    feed(11);
    chk("relock_wc", int'(wrap_count), 1);
    chk("relock_len", int'(period_len), 12);

    // Stalled counter held at 5.
    feed(5);
    wp_cnt = 0;
`ifdef COUNT_WRAP_MONITOR_STEP_CHECK_EN
    tick(5);
    chk("stall_step_err", int'(err_flag), 1);
    repeat (24) tick(5);
`else
    repeat (24) tick(5);
    chk("stall_pre", int'(locked), 1);
    tick(5);
    chk("stall_err", int'(err_flag), 1);
`endif
    chk("stall_wp", wp_cnt, 0);

    // Skipped value: 0,1,2,4..11.
    clr = 1'b1;
    tick(0);
    clr = 1'b0;
    for (int i = 1; i <= 11; i++) tick(i);
    feed(11);
    feed(11);
    chk("skip_pre_wc", int'(wrap_count), 1);
    tick(0);
    tick(1);
    tick(2);
    tick(4);
`ifdef COUNT_WRAP_MONITOR_STEP_CHECK_EN
    chk("skip_step_err", int'(err_flag), 1);
`else
    chk("skip_step_err", int'(err_flag), 0);
`endif
    for (int i = 5; i <= 11; i++) tick(i);
    tick(0);
`ifdef COUNT_WRAP_MONITOR_STEP_CHECK_EN
    chk("skip_len", int'(period_len), 12);
    chk("skip_wc", int'(wrap_count), 2);
`else
    chk("skip_len", int'(period_len), 11);
    chk("skip_wc", int'(wrap_count), 3);
`endif
    chk("skip_err", int'(err_flag), 1);

    // Reset mid-period while locked.
    clr = 1'b1;
    tick(0);
    clr = 1'b0;
    for (int i = 1; i <= 11; i++) tick(i);
    feed(11);
    feed(11);
    chk("mr_pre_lock", int'(locked), 1);
    for (int i = 0; i <= 5; i++) tick(i);
    rst_n = 1'b0;
    #1;
    chk("mr_async", outs_or(), 0);
    tick(6);
    tick(7);
    tick(8);
    chk("mr_hold", outs_or(), 0);
    rst_n = 1'b1;
    tick(9);
    tick(10);
    tick(11);
    chk("mr_sync", int'(locked), 0);
    feed(11);
    chk("mr_lock", int'(locked), 1);
    chk("mr_wc0", int'(wrap_count), 0);
    feed(11);
    chk("mr_wc1", int'(wrap_count), 1);
    chk("mr_len", int'(period_len), 12);

    // exp_mod = 0 with a constant 0 stream: never locks, never faults.
    exp_mod = 4'd0;
    do_reset();
    wp_cnt = 0;
    repeat (40) tick(0);
    chk("m0_lock", int'(locked), 0);
    chk("m0_err", int'(err_flag), 0);
    chk("m0_wp", wp_cnt, 0);

    // exp_mod = 15 for 300 wraps.
    exp_mod = 4'd15;
    do_reset();
    feed(15);
    feed(15);
    chk("m15_lock", int'(locked), 1);
    bad = 0;
    pvs = 0;
    for (int n = 0; n < 300; n++) begin
      feed(15);
      if (period_len != 5'd16) bad++;
      pvs += pv_cnt;
    end
    chk("m15_badlen", bad, 0);
    chk("m15_pvs", pvs, 300);
    chk("m15_wc", int'(wrap_count), 44);
    chk("m15_err", int'(err_flag), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/count_wrap_monitor.md
COUNT_WRAP_MONITOR -- requirements
Module: count_wrap_monitor

Interface
REQ-001 The block SHALL have one clock: clk, input, 1 bit, rising-edge; all state SHALL be registered on it.
REQ-002 The block SHALL have rst_n, input, 1 bit, an asynchronous active-low reset.
REQ-003 cnt_in SHALL be an input, 4 bits: the count value from the upstream up-counter, sampled every rising edge.
REQ-004 exp_mod SHALL be an input, 4 bits: the expected terminal value N; the expected period is N+1 cycles.
REQ-005 clr SHALL be an input, 1 bit: synchronous clear of the monitor.
REQ-006 wrap_pulse SHALL be an output, 1 bit: a one-cycle pulse per detected wrap.
REQ-007 period_len SHALL be an output, 5 bits: the last measured cycles-per-wrap.
REQ-008 period_valid SHALL be an output, 1 bit: a one-cycle strobe when period_len updates.
REQ-009 wrap_count SHALL be an output, 8 bits: the number of wraps since lock, modulo 256.
REQ-010 locked SHALL be an output, 1 bit: high in state LOCK.
REQ-011 err_flag SHALL be an output, 1 bit: high in state FAULT (sticky).

Function
REQ-012 Internal prev (4 bits) SHALL load cnt_in on every edge; a wrap event SHALL be an edge where cnt_in < prev (unsigned) and a prior sample exists.
REQ-013 The FSM SHALL have states IDLE, SYNC, LOCK and FAULT; IDLE SHALL go to SYNC on the first edge after reset release (first sample taken).
REQ-014 SYNC SHALL go to LOCK on the first wrap event; exp_mod SHALL be captured into exp_q on that edge, and exp_q SHALL be used for all later checks.
REQ-015 Cycle counter cyc (5 bits) SHALL load 1 on a wrap edge, SHALL increment otherwise, and SHALL saturate at 31.
REQ-016 On a wrap edge in LOCK: period_len SHALL take cyc, period_valid SHALL pulse for the next cycle, and wrap_count SHALL increment with wrap 255->0.
REQ-017 wrap_pulse SHALL be registered: high for exactly one cycle following any wrap edge in SYNC or LOCK.
REQ-018 In LOCK, a wrap edge with cyc != exp_q+1 SHALL move the FSM to FAULT on that same edge; period_len/period_valid SHALL still update for that wrap.
REQ-019 In LOCK, cyc reaching 31 (stalled counter) SHALL move the FSM to FAULT.
REQ-020 FAULT SHALL hold; wrap_pulse SHALL still fire, while period_valid and wrap_count SHALL freeze.
REQ-021 clr=1 in any state SHALL, on that edge, set state=SYNC, wrap_count=0, period_len=0 and cyc=0; clr SHALL take priority over a simultaneous wrap or fault condition.
REQ-022 exp_mod=0 SHALL produce no wrap, so the FSM SHALL stay in SYNC indefinitely; this is not an error.

Reset
REQ-023 While rst_n=0: state=IDLE; prev, cyc, period_len, wrap_count and exp_q SHALL be 0; all 1-bit outputs SHALL be 0.
REQ-024 An assertion of rst_n mid-period SHALL discard the partial measurement; after release the block SHALL re-acquire via IDLE->SYNC->LOCK.

Configuration
REQ-025 Macro COUNT_WRAP_MONITOR_STEP_CHECK_EN, when defined, SHALL enable a per-edge sequence check in LOCK: cnt_in SHALL equal (prev==exp_q ? 0 : prev+1 mod 16), and any mismatch SHALL move the FSM to FAULT on that edge.
REQ-026 When COUNT_WRAP_MONITOR_STEP_CHECK_EN is undefined, only the period checks of REQ-018 and REQ-019 SHALL apply, and no step-check logic SHALL be synthesized.

Verification
REQ-027 The bench SHALL apply exp_mod=11 with a clean 0..11 stream -> locked after first wrap; period_len=12 with period_valid every 12 cycles; wrap_count increments; err_flag=0.
REQ-028 The bench SHALL apply exp_mod=11 while the stream wraps at 9 -> first post-lock wrap gives period_len=10 and FAULT/err_flag=1; a later clr pulse gives locked=0 and err_flag=0, then relock.
REQ-029 The bench SHALL hold cnt_in constant at 5 while in LOCK -> FAULT when cyc hits 31; wrap_pulse stays 0.
REQ-030 With STEP_CHECK_EN defined, the bench SHALL send the stream 0,1,2,4,5..11 -> FAULT on the edge sampling 4; with STEP_CHECK_EN undefined, the same stream gives period_len=11 and FAULT at the wrap.
REQ-031 The bench SHALL assert rst_n=0 for 3 cycles mid-period in LOCK -> all outputs 0, state IDLE; after release, relock at the next wrap with wrap_count restarting at 1.
REQ-032 The bench SHALL run exp_mod=15 for 300 wraps -> period_len=16 throughout and wrap_count reads 300 mod 256 = 44.
